kb_digit_entry: RTL and testbench
=================================

// Module: kb_digit_entry
// PURPOSE
//  Consumes PS/2 key codes from the kb_code receive FIFO and assembles a 1-2 digit decimal index.
//  Edits: Backspace, Esc. Commit: Enter.
//  Produces a range-checked binary index with a one-cycle commit strobe for the fib stage's i/start inputs.
//  Sits between kb_code (upstream) and fib (downstream); replaces ad-hoc two-byte capture.
// PARAMETERS
//  W          6       width of committed index idx
//  MAX_IDX    40      largest legal index; larger entries are rejected
// PORTS
//  clk          in   1  system clock, all state on rising edge
//  reset        in   1  asynchronous, active-low reset
//  kb_buf_empty in   1  upstream FIFO empty flag (first-word-fall-through)
//  key_code     in   8  head-of-FIFO scan code (set 2 make code), valid when kb_buf_empty=0
//  rd_key_code  out  1  pop strobe to upstream FIFO
//  idx          out  W  last committed index, held stable between commits
//  idx_tick     out  1  one-cycle pulse: idx updated
//  err_tick     out  1  one-cycle pulse: rejected key/entry
//  d_tens       out  4  BCD tens digit of entry in progress (display)
//  d_ones       out  4  BCD ones digit of entry in progress (display)
//  ndig         out  2  digits currently entered (0..2)
// BEHAVIOUR
//  Reset (async, reset=0): state=EMPTY, idx=0, idx_tick=0, err_tick=0, d_tens=0, d_ones=0, ndig=0, rd_key_code=0.
//  Handshake: rd_key_code = reset & ~kb_buf_empty (combinational); key_code consumed same cycle; max one code/cycle.
//  Digit map: 45->0 16->1 1E->2 26->3 25->4 2E->5 36->6 3D->7 3E->8 46->9.
//  Controls: 5A=Enter, 66=Backspace, 76=Esc. Any other code: popped, ignored, no tick.
//  FSM (ndig mirrors state):
//   EMPTY: digit d -> ONE, d_ones=d, d_tens=0. Backspace/Esc -> no effect. Enter -> ignored, no tick.
//   ONE: digit d -> TWO, d_tens=d_ones, d_ones=d. Backspace/Esc -> EMPTY, digits cleared. Enter -> commit.
//   TWO: digit -> err_tick, entry unchanged (no third digit).
//   TWO: Backspace -> ONE, d_ones=d_tens, d_tens=0. Esc -> EMPTY, digits cleared. Enter -> commit.
//  Commit: v = d_tens*10 + d_ones, 7-bit, computed as (t<<3)+(t<<1)+o.
//   If v<=MAX_IDX: idx<=v[W-1:0], idx_tick=1.
//   Else: err_tick=1, idx unchanged.
//   Either way -> EMPTY, digits cleared.
//  Latency: code popped in cycle N -> digit regs/ndig/idx and ticks valid after edge ending N (visible cycle N+1).
//  Ticks are high exactly one cycle; idx_tick and err_tick never high together.
//  Back-to-back codes every cycle processed in order; ticks may then occur on consecutive cycles.
//  kb_buf_empty=1: no pop, state holds, ticks low.
//  reset asserted mid-entry: entry discarded, all outputs to reset values immediately (async).
//  Leading zero legal: "0","7",Enter -> idx=7.
// TESTING
//  1 keys 16,1E,5A (1,2,Enter) -> idx_tick one cycle after 5A pop, idx=12, ndig=0.
//  2 keys 26,46,5A ("39") -> idx=39, idx_tick.
//    keys 25,45,16,5A ("4","0","1",Enter) -> err_tick on 16; commit "40" -> idx=40.
//  3 keys 25,16,5A ("41"), MAX_IDX=40 -> err_tick=1, idx_tick=0, idx keeps previous value.
//  4 keys 36,3D,66,1E,5A ("6","7",Bksp,"2",Enter) -> after 66 ndig=1, d_ones=6; final idx=62 rejected (err_tick).
//    Same with 16 instead of 1E: idx=61 rejected; with MAX_IDX=63 -> idx=61.
//  5 Enter (5A) in EMPTY -> no tick, idx unchanged.
//    Key 29 (space) -> popped, no effect.
//    76 after one digit -> ndig=0.
//  6 Entry "3" then reset low for 2 cycles mid-stream -> idx=0, ndig=0, rd_key_code=0 during reset.
//    Stream of 4 codes with kb_buf_empty=0 for 4 consecutive cycles -> exactly 4 pops, correct result.

Source files
------------

// File: rtl/kb_digit_entry_if.sv
// kb_digit_entry_if
//  Groups the key-code FIFO handshake and the index/display outputs of
//  kb_digit_entry into a single bundle.
//  master : upstream FIFO / consumer side (drives FIFO status and key code)
//  slave  : kb_digit_entry side (pops codes, drives index, ticks, display)
//  Signals:
//    kb_buf_empty  FIFO empty flag (first-word-fall-through)
//    key_code      head-of-FIFO scan code, valid when kb_buf_empty=0
//    rd_key_code   pop strobe back to the FIFO
//    idx           last committed index
//    idx_tick      one-cycle pulse when idx updates
//    err_tick      one-cycle pulse on a rejected key or entry
//    d_tens/d_ones BCD digits of the entry in progress
//    ndig          number of digits currently entered (0..2)
interface kb_digit_entry_if #(
  parameter int W = 6
);
  logic         kb_buf_empty;
  logic [7:0]   key_code;
  logic         rd_key_code;
  logic [W-1:0] idx;
  logic         idx_tick;
  logic         err_tick;
  logic [3:0]   d_tens;
  logic [3:0]   d_ones;
  logic [1:0]   ndig;

  modport master (
    output kb_buf_empty, key_code,
    input  rd_key_code, idx, idx_tick, err_tick, d_tens, d_ones, ndig
  );

  modport slave (
    input  kb_buf_empty, key_code,
    output rd_key_code, idx, idx_tick, err_tick, d_tens, d_ones, ndig
  );
endinterface

// File: rtl/kb_digit_entry.sv
// kb_digit_entry
//  Pops PS/2 set-2 make codes from the kb_code FIFO and assembles a one or
//  two digit decimal index. Backspace removes the last digit, Esc clears the
//  entry, Enter commits it. A committed value above MAX_IDX is rejected with
//  err_tick; an accepted one updates idx and pulses idx_tick.
//  Ports:
//    clk    system clock, all state on rising edge
//    reset  asynchronous, active-low reset
//    bus    kb_digit_entry_if slave modport (FIFO handshake, idx, ticks,
//           display digits, digit count)
module kb_digit_entry #(
  parameter int W       = 6,
  parameter int MAX_IDX = 40
) (
  input  logic             clk,
  input  logic             reset,
  kb_digit_entry_if.slave  bus
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_e;

  localparam logic [6:0] MAX_V = 7'(MAX_IDX);

  state_e       state_q;
  logic [W-1:0] idx_q;
  logic         idx_tick_q;
  logic         err_tick_q;
  logic [3:0]   tens_q;
  logic [3:0]   ones_q;

  logic         pop;
  logic         is_digit;
  logic [3:0]   digit;
  logic         is_enter;
  logic         is_bksp;
  logic         is_esc;
  logic [6:0]   value;

  // The FIFO is first-word-fall-through, so the head code is consumed in the
  // same cycle it is popped; no pop is issued while reset is held.
  assign pop = reset & ~bus.kb_buf_empty;

  always_comb begin
    is_digit = 1'b1;
    digit    = 4'd0;
    case (bus.key_code)
      8'h45:   digit = 4'd0;
      8'h16:   digit = 4'd1;
      8'h1E:   digit = 4'd2;
      8'h26:   digit = 4'd3;
      8'h25:   digit = 4'd4;
      8'h2E:   digit = 4'd5;
      8'h36:   digit = 4'd6;
      8'h3D:   digit = 4'd7;
      8'h3E:   digit = 4'd8;
      8'h46:   digit = 4'd9;
      default: is_digit = 1'b0;
    endcase
  end

  assign is_enter = (bus.key_code == 8'h5A);
  assign is_bksp  = (bus.key_code == 8'h66);
  assign is_esc   = (bus.key_code == 8'h76);

  // tens*10 + ones without a multiplier; tens_q is zero in S_ONE so the same
  // expression serves single-digit entries.
  assign value = ({3'b000, tens_q} << 3) + ({3'b000, tens_q} << 1) + {3'b000, ones_q};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_EMPTY;
      idx_q      <= '0;
      idx_tick_q <= 1'b0;
      err_tick_q <= 1'b0;
      tens_q     <= 4'd0;
      ones_q     <= 4'd0;
    end else begin
      idx_tick_q <= 1'b0;
      err_tick_q <= 1'b0;
      if (pop) begin
        case (state_q)
          S_EMPTY: begin
            // Edits and Enter on an empty entry are silently ignored.
            if (is_digit) begin
              state_q <= S_ONE;
              ones_q  <= digit;
              tens_q  <= 4'd0;
            end
          end
          S_ONE: begin
            if (is_digit) begin
              state_q <= S_TWO;
              tens_q  <= ones_q;
              ones_q  <= digit;
            end else if (is_bksp || is_esc) begin
              state_q <= S_EMPTY;
              tens_q  <= 4'd0;
              ones_q  <= 4'd0;
            end else if (is_enter) begin
              if (value <= MAX_V) begin
                idx_q      <= value[W-1:0];
                idx_tick_q <= 1'b1;
              end else begin
                err_tick_q <= 1'b1;
              end
              state_q <= S_EMPTY;
              tens_q  <= 4'd0;
              ones_q  <= 4'd0;
            end
          end
          S_TWO: begin
            if (is_digit) begin
              // No room for a third digit: flag it, keep the entry.
              err_tick_q <= 1'b1;
            end else if (is_bksp) begin
              state_q <= S_ONE;
              ones_q  <= tens_q;
              tens_q  <= 4'd0;
            end else if (is_esc) begin
              state_q <= S_EMPTY;
              tens_q  <= 4'd0;
              ones_q  <= 4'd0;
            end else if (is_enter) begin
              if (value <= MAX_V) begin
                idx_q      <= value[W-1:0];
                idx_tick_q <= 1'b1;
              end else begin
                err_tick_q <= 1'b1;
              end
              state_q <= S_EMPTY;
              tens_q  <= 4'd0;
              ones_q  <= 4'd0;
            end
          end
          default: begin
            state_q <= S_EMPTY;
            tens_q  <= 4'd0;
            ones_q  <= 4'd0;
          end
        endcase
      end
    end
  end

  assign bus.rd_key_code = pop;
  assign bus.idx         = idx_q;
  assign bus.idx_tick    = idx_tick_q;
  assign bus.err_tick    = err_tick_q;
  assign bus.d_tens      = tens_q;
  assign bus.d_ones      = ones_q;
  // The state encoding is the digit count.
  assign bus.ndig        = state_q;

endmodule

// File: tb/tb_kb_digit_entry.sv
// tb_kb_digit_entry
//  Directed and random key streams into kb_digit_entry, compared every cycle
//  against a queue-of-digits reference model of the entry behaviour.
module tb_kb_digit_entry;

  localparam int MAX_IDX = 40;

  logic clk;
  logic reset;

  kb_digit_entry_if #(.W(6)) bus ();

  kb_digit_entry #(.W(6), .MAX_IDX(MAX_IDX)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int pops      = 0;

  always @(posedge clk) if (bus.rd_key_code === 1'b1) pops++;

  // Reference model: digits entered so far, most significant first.
  int q[$];
  int m_idx   = 0;
  int m_itick = 0;
  int m_etick = 0;

  logic [7:0] digit_codes [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25,
                                   8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};

  function automatic int digit_of(input logic [7:0] c);
    for (int i = 0; i < 10; i++) if (digit_codes[i] == c) return i;
    return -1;
  endfunction

  task automatic model_apply(input logic [7:0] c);
    int d;
    int v;
    m_itick = 0;
    m_etick = 0;
    d = digit_of(c);
    if (d >= 0) begin
      if (q.size() < 2) q.push_back(d);
      else m_etick = 1;
    end else if (c == 8'h66) begin
      if (q.size() > 0) q.delete(q.size() - 1);
    end else if (c == 8'h76) begin
      q.delete();
    end else if (c == 8'h5A) begin
      if (q.size() > 0) begin
        v = 0;
        foreach (q[i]) v = v * 10 + q[i];
        if (v <= MAX_IDX) begin
          m_idx   = v;
          m_itick = 1;
        end else begin
          m_etick = 1;
        end
        q.delete();
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0d expected %0d (t=%0t)", tag, obs, exp, $time);
  endtask

  task automatic check_outputs(input string ctx);
    chk({ctx, " idx"},      32'(bus.idx),      32'(m_idx));
    chk({ctx, " idx_tick"}, 32'(bus.idx_tick), 32'(m_itick));
    chk({ctx, " err_tick"}, 32'(bus.err_tick), 32'(m_etick));
    chk({ctx, " ndig"},     32'(bus.ndig),     32'(q.size()));
    chk({ctx, " d_ones"},   32'(bus.d_ones),   32'((q.size() > 0) ? q[q.size()-1] : 0));
    chk({ctx, " d_tens"},   32'(bus.d_tens),   32'((q.size() == 2) ? q[0] : 0));
  endtask

  // One clock cycle: present a code (or nothing), check the combinational
  // pop, then check registered outputs after the edge.
  task automatic step(input bit valid, input logic [7:0] code);
    string ctx;
    @(negedge clk);
    bus.kb_buf_empty = !valid;
    bus.key_code     = code;
    #1;
    ctx = $sformatf("code %02h v%0d", code, valid);
    chk({ctx, " rd_key_code"}, 32'(bus.rd_key_code), 32'(valid));
    @(posedge clk);
    #1;
    if (valid) model_apply(code);
    else begin
      m_itick = 0;
      m_etick = 0;
    end
    check_outputs(ctx);
    $display("step code=%02h valid=%0d idx=%0d itick=%0d etick=%0d ndig=%0d tens=%0d ones=%0d",
             code, valid, bus.idx, bus.idx_tick, bus.err_tick, bus.ndig, bus.d_tens, bus.d_ones);
  endtask

  task automatic keys(input logic [7:0] c0, input logic [7:0] c1,
                      input logic [7:0] c2, input logic [7:0] c3, input int n);
    logic [7:0] cs [4];
    cs = '{c0, c1, c2, c3};
    for (int i = 0; i < n; i++) step(1'b1, cs[i]);
    step(1'b0, 8'h00);
  endtask

  initial begin
    int p0;
    int sel;
    logic [7:0] c;
    reset            = 1'b0;
    bus.kb_buf_empty = 1'b1;
    bus.key_code     = 8'h00;
    #1;
    check_outputs("reset");
    chk("reset rd_key_code", 32'(bus.rd_key_code), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;

    // 1: "12" Enter
    keys(8'h16, 8'h1E, 8'h5A, 8'h00, 3);
    chk("t1 idx=12", 32'(bus.idx), 32'd12);
    // 2: "39", then "4","0",third digit rejected, commit "40"
    keys(8'h26, 8'h46, 8'h5A, 8'h00, 3);
    keys(8'h25, 8'h45, 8'h16, 8'h5A, 4);
    chk("t2 idx=40", 32'(bus.idx), 32'd40);
    // 3: "41" rejected, idx keeps 40
    keys(8'h25, 8'h16, 8'h5A, 8'h00, 3);
    chk("t3 idx held", 32'(bus.idx), 32'd40);
    // 4: "6","7",Bksp,"2",Enter -> 62 rejected; same with "1" -> 61 rejected
    keys(8'h36, 8'h3D, 8'h66, 8'h00, 3);
    chk("t4 ndig after bksp", 32'(bus.ndig), 32'd1);
    chk("t4 d_ones after bksp", 32'(bus.d_ones), 32'd6);
    keys(8'h1E, 8'h5A, 8'h00, 8'h00, 2);
    keys(8'h36, 8'h3D, 8'h66, 8'h16, 4);
    keys(8'h5A, 8'h00, 8'h00, 8'h00, 1);
    // 5: Enter while empty, space key, Esc after one digit
    keys(8'h5A, 8'h29, 8'h26, 8'h76, 4);
    chk("t5 ndig after esc", 32'(bus.ndig), 32'd0);
    // 6: leading zero and back-to-back stream of 4 codes
    p0 = pops;
    keys(8'h45, 8'h3D, 8'h29, 8'h5A, 4);
    chk("t6 pops", 32'(pops - p0), 32'd4);
    chk("t6 idx=7", 32'(bus.idx), 32'd7);

    // Reset mid-entry with codes pending
    step(1'b1, 8'h26);
    @(negedge clk);
    bus.kb_buf_empty = 1'b0;
    bus.key_code     = 8'h16;
    #2;
    reset = 1'b0;
    #1;
    q.delete();
    m_idx   = 0;
    m_itick = 0;
    m_etick = 0;
    check_outputs("async reset");
    chk("async reset rd_key_code", 32'(bus.rd_key_code), 32'd0);
    p0 = pops;
    repeat (2) @(posedge clk);
    #1;
    chk("reset no pops", 32'(pops - p0), 32'd0);
    check_outputs("held reset");
    @(negedge clk);
    bus.kb_buf_empty = 1'b1;
    reset = 1'b1;
    keys(8'h26, 8'h5A, 8'h00, 8'h00, 2);

    // Random stream
    for (int n = 0; n < 400; n++) begin
      sel = $urandom_range(0, 9);
      if (sel <= 5)      c = digit_codes[$urandom_range(0, 9)];
      else if (sel == 6) c = 8'h5A;
      else if (sel == 7) c = 8'h66;
      else if (sel == 8) c = 8'h76;
      else               c = 8'($urandom);
      step($urandom_range(0, 4) != 0, c);
    end
    step(1'b0, 8'h00);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
